// File: rtl/alsu_seq_pkg.sv
// Shared opcodes, FSM state codes and command validity rule for the sequential ALSU.
package alsu_seq_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  // Reduction only makes sense for the two bitwise opcodes.
  function automatic logic cmd_invalid(input logic [2:0] op, input logic red_a,
                                       input logic red_b);
    return (op == 3'b110) || (op == 3'b111) || ((red_a || red_b) && (op >= OP_ADD));
  endfunction

endpackage

// File: rtl/alsu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alsu_mul_seq
  import alsu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned OUT_W = 2 * WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] product
);

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] addend;

  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CNT_W'(1));
  assign addend  = mplier_q[0] ? mcand_q : '0;
  // Running sum including this cycle's partial product; final on the done cycle.
  assign product = acc_q + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= OUT_W'(a);
      mplier_q <= b;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (busy) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alsu_seq.sv
// Handshaked arithmetic/logic/shift unit with registered command, registered result,
// bypass/reduction priority, invalid-command LED blink and an iterative multiplier.
module alsu_seq
  import alsu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER = "ON",
  parameter int unsigned LED_W = 16,
  localparam int unsigned OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             err,
  output logic [LED_W-1:0] leds
);

  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             cin_q, sin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q;

  logic             byp, use_a_byp, red_sel_a, bad, start_mul;
  logic [WIDTH:0]   sum;
  logic [OUT_W-1:0] result;
  logic             mul_busy, mul_done;
  logic [OUT_W-1:0] mul_product;

  assign in_ready  = (state_q == IDLE);
  assign byp       = byp_a_q || byp_b_q;
  assign use_a_byp = byp_a_q && (!byp_b_q || PRIO_A);
  assign red_sel_a = red_a_q && (!red_b_q || PRIO_A);
  assign bad       = !byp && cmd_invalid(op_q, red_a_q, red_b_q);
  assign start_mul = (state_q == EXEC) && !byp && !bad && (op_q == OP_MUL);
  assign sum       = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(cin_q & FA_ON);

  always_comb begin
    result = '0;
    if (byp) begin
      result[WIDTH-1:0] = use_a_byp ? a_q : b_q;
    end else if (!bad) begin
      case (op_q)
        OP_AND: begin
          if (red_a_q || red_b_q) result[0] = red_sel_a ? &a_q : &b_q;
          else                    result[WIDTH-1:0] = a_q & b_q;
        end
        OP_XOR: begin
          if (red_a_q || red_b_q) result[0] = red_sel_a ? ^a_q : ^b_q;
          else                    result[WIDTH-1:0] = a_q ^ b_q;
        end
        OP_ADD:   result[WIDTH:0] = sum;
        OP_SHIFT: result = dir_q ? {out[OUT_W-2:0], sin_q} : {sin_q, out[OUT_W-1:1]};
        OP_ROT:   result = dir_q ? {out[OUT_W-2:0], out[OUT_W-1]} : {out[0], out[OUT_W-1:1]};
        default:  result = '0;
      endcase
    end
  end

  alsu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .a      (a_q),
    .b      (b_q),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cin_q     <= 1'b0;
      sin_q     <= 1'b0;
      red_a_q   <= 1'b0;
      red_b_q   <= 1'b0;
      byp_a_q   <= 1'b0;
      byp_b_q   <= 1'b0;
      dir_q     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      leds      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= opcode;
            cin_q   <= cin;
            sin_q   <= serial_in;
            red_a_q <= red_op_A;
            red_b_q <= red_op_B;
            byp_a_q <= bypass_A;
            byp_b_q <= bypass_B;
            dir_q   <= direction;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (start_mul) begin
            state_q <= MUL;
          end else begin
            out       <= result;
            err       <= bad;
            leds      <= bad ? ~leds : '0;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        MUL: begin
          if (mul_busy && mul_done) begin
            out       <= mul_product;
            err       <= 1'b0;
            leds      <= '0;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_seq.sv
// Bench for alsu_seq: two instances (priority A + full adder, priority B + no carry)
// driven in lockstep and checked against an arithmetic reference model.
module tb_alsu_seq;

  localparam int W  = 4;
  localparam int OW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [2:0]    opcode;
  logic          cin, serial_in, red_op_a, red_op_b, bypass_a, bypass_b, direction;
  logic          in_ready_a, out_valid_a, err_a;
  logic          in_ready_b, out_valid_b, err_b;
  logic [OW-1:0] out_a, out_b;
  logic [LW-1:0] leds_a, leds_b;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] op;
    logic cin, sin, ra, rb, ba, bb, dir;
  } cmd_t;

  // Index 0 models u_dut_a, index 1 models u_dut_b.
  logic [7:0]  m_out[2];
  logic [15:0] m_leds[2];
  logic        m_err[2];

  alsu_seq #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LW)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .A(a), .B(b),
    .opcode(opcode), .cin(cin), .serial_in(serial_in), .red_op_A(red_op_a),
    .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b), .direction(direction),
    .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .err(err_a), .leds(leds_a)
  );

  alsu_seq #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(LW)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .A(a), .B(b),
    .opcode(opcode), .cin(cin), .serial_in(serial_in), .red_op_A(red_op_a),
    .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b), .direction(direction),
    .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .err(err_b), .leds(leds_b)
  );

  function automatic cmd_t mk(input logic [3:0] ca, input logic [3:0] cb, input logic [2:0] op);
    cmd_t c;
    c.a = ca; c.b = cb; c.op = op;
    c.cin = 0; c.sin = 0; c.ra = 0; c.rb = 0; c.ba = 0; c.bb = 0; c.dir = 0;
    return c;
  endfunction

  function automatic void model(input cmd_t c, input bit prio_b, input bit fa_on,
                                input int prev_o, input int prev_l,
                                output int o, output int l, output bit e, output bit mul);
    logic [3:0] sel;
    o = 0; l = 0; e = 0; mul = 0;
    sel = (c.ra && (!c.rb || !prio_b)) ? c.a : c.b;
    if (c.ba || c.bb) begin
      o = (c.ba && (!c.bb || !prio_b)) ? int'(c.a) : int'(c.b);
    end else if (c.op >= 6 || ((c.ra || c.rb) && c.op >= 2)) begin
      e = 1; l = prev_l ^ 'hFFFF;
    end else begin
      case (c.op)
        3'd0: o = (c.ra || c.rb) ? int'(sel == 4'hF) : int'(c.a & c.b);
        3'd1: o = (c.ra || c.rb) ? $countones(sel) % 2 : int'(c.a ^ c.b);
        3'd2: o = int'(c.a) + int'(c.b) + (fa_on ? int'(c.cin) : 0);
        3'd3: begin o = int'(c.a) * int'(c.b); mul = 1; end
        3'd4: o = c.dir ? (prev_o * 2 + int'(c.sin)) % 256 : prev_o / 2 + int'(c.sin) * 128;
        default: o = c.dir ? (prev_o * 2 + prev_o / 128) % 256 : prev_o / 2 + (prev_o % 2) * 128;
      endcase
    end
  endfunction

  task automatic apply_model(input cmd_t c, output int exp_lat);
    int o, l;
    bit e, m;
    m = 0;
    for (int i = 0; i < 2; i++) begin
      model(c, i == 1, i == 0, int'(m_out[i]), int'(m_leds[i]), o, l, e, m);
      m_out[i] = 8'(o); m_leds[i] = 16'(l); m_err[i] = e;
    end
    exp_lat = m ? W + 2 : 2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0; m_leds[i] = '0; m_err[i] = 1'b0;
    end
  endtask

  task automatic drive(input cmd_t c);
    a = c.a; b = c.b; opcode = c.op; cin = c.cin; serial_in = c.sin;
    red_op_a = c.ra; red_op_b = c.rb; bypass_a = c.ba; bypass_b = c.bb; direction = c.dir;
  endtask

  task automatic scramble();
    a = 4'($urandom); b = 4'($urandom); opcode = 3'($urandom); cin = 1'($urandom);
    serial_in = 1'($urandom); red_op_a = 1'($urandom); red_op_b = 1'($urandom);
    bypass_a = 1'($urandom); bypass_b = 1'($urandom); direction = 1'($urandom);
  endtask

  // Accept one command; lat counts edges from the accept edge (inclusive) to out_valid.
  task automatic run_cmd(input cmd_t c, output int lat, output bit busy_ready);
    @(negedge clk);
    drive(c);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    lat = 1;
    busy_ready = 0;
    while (!out_valid_a && lat < 40) begin
      if (in_ready_a || in_ready_b) busy_ready = 1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++; if ({in_ready_a, in_ready_b} !== 2'b11)
      $display("FAIL reset_in_ready: got %b want 11", {in_ready_a, in_ready_b}); else passed++;
    checks++; if ({out_valid_a, out_valid_b} !== 2'b00)
      $display("FAIL reset_out_valid: got %b want 00", {out_valid_a, out_valid_b}); else passed++;
    checks++; if ({out_a, out_b} !== 16'h0)
      $display("FAIL reset_out: got %h want 0000", {out_a, out_b}); else passed++;
    checks++; if ({err_a, err_b} !== 2'b00)
      $display("FAIL reset_err: got %b want 00", {err_a, err_b}); else passed++;
    checks++; if ({leds_a, leds_b} !== 32'h0)
      $display("FAIL reset_leds: got %h want 0", {leds_a, leds_b}); else passed++;
  endtask

  task automatic test_and();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'hC, 4'hA, 3'd0);
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (lat !== 2) $display("FAIL and_latency: got %0d want 2", lat); else passed++;
    checks++; if (out_a !== 8'h08 || out_b !== 8'h08)
      $display("FAIL and_out: got %h/%h want 08/08", out_a, out_b); else passed++;
    checks++; if (err_a !== 1'b0) $display("FAIL and_err: got %b want 0", err_a); else passed++;
    release_result();
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
      $display("FAIL and_release: got valid=%b ready=%b want 0/1", out_valid_a, in_ready_a);
    else passed++;
  endtask

  task automatic test_add();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'hF, 4'hF, 3'd2);
    c.cin = 1'b1;
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (out_a !== 8'h1F) $display("FAIL add_full: got %h want 1f", out_a); else passed++;
    checks++; if (out_b !== 8'h1E) $display("FAIL add_nocin: got %h want 1e", out_b); else passed++;
    release_result();
  endtask

  task automatic test_mul();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'hF, 4'hF, 3'd3);
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (lat !== W + 2) $display("FAIL mul_latency: got %0d want %0d", lat, W + 2);
    else passed++;
    checks++; if (br !== 1'b0) $display("FAIL mul_in_ready: got high while busy want low");
    else passed++;
    checks++; if (out_a !== 8'hE1 || out_b !== 8'hE1)
      $display("FAIL mul_out: got %h/%h want e1/e1", out_a, out_b); else passed++;
    release_result();
  endtask

  task automatic test_invalid();
    cmd_t c;
    int el, lat;
    bit br;
    logic [15:0] want_leds[2];
    want_leds[0] = 16'hFFFF;
    want_leds[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      c = mk(4'h9, 4'h6, 3'd6);
      apply_model(c, el);
      run_cmd(c, lat, br);
      checks++; if (leds_a !== want_leds[i] || leds_b !== want_leds[i])
        $display("FAIL invalid_leds_%0d: got %h/%h want %h", i, leds_a, leds_b, want_leds[i]);
      else passed++;
      checks++; if (out_a !== 8'h00 || err_a !== 1'b1)
        $display("FAIL invalid_out_err_%0d: got %h/%b want 00/1", i, out_a, err_a); else passed++;
      release_result();
    end
    c = mk(4'hC, 4'hA, 3'd0);
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (err_a !== 1'b0 || leds_a !== 16'h0 || out_a !== 8'h08)
      $display("FAIL invalid_recover: got err=%b leds=%h out=%h want 0/0000/08",
               err_a, leds_a, out_a);
    else passed++;
    release_result();
  endtask

  task automatic test_bypass_backpressure();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'h3, 4'h5, 3'd0);
    c.ba = 1'b1; c.bb = 1'b1;
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (out_b !== 8'h05) $display("FAIL bypass_prio_b: got %h want 05", out_b);
    else passed++;
    checks++; if (out_a !== 8'h03) $display("FAIL bypass_prio_a: got %h want 03", out_a);
    else passed++;
    // Offer a different command while the result is stalled; it must be ignored.
    drive(mk(4'hE, 4'h7, 3'd2));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_b !== 8'h05 || out_valid_b !== 1'b1 || in_ready_b !== 1'b0)
        $display("FAIL stall_%0d: got out=%h valid=%b ready=%b want 05/1/0",
                 i, out_b, out_valid_b, in_ready_b);
      else passed++;
    end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_shift_rotate();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'h0, 4'h0, 3'd4);
    c.dir = 1'b1; c.sin = 1'b1;
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (out_b !== 8'h0B || out_a !== 8'h07)
      $display("FAIL shift_left: got %h/%h want 07/0b", out_a, out_b); else passed++;
    release_result();
    c = mk(4'h0, 4'h0, 3'd5);
    c.dir = 1'b0; c.sin = 1'b0;
    apply_model(c, el);
    run_cmd(c, lat, br);
    checks++; if (out_b !== 8'h85 || out_a !== 8'h83)
      $display("FAIL rotate_right: got %h/%h want 83/85", out_a, out_b); else passed++;
    release_result();
  endtask

  task automatic test_random();
    cmd_t c;
    int el, lat;
    bit br;
    for (int n = 0; n < 40; n++) begin
      c = mk(4'($urandom), 4'($urandom), 3'($urandom));
      c.cin = 1'($urandom); c.sin = 1'($urandom); c.dir = 1'($urandom);
      c.ra = ($urandom_range(0, 3) == 0); c.rb = ($urandom_range(0, 3) == 0);
      c.ba = ($urandom_range(0, 4) == 0); c.bb = ($urandom_range(0, 4) == 0);
      apply_model(c, el);
      run_cmd(c, lat, br);
      checks++; if (lat !== el || br !== 1'b0 || out_valid_b !== 1'b1)
        $display("FAIL rand_%0d_timing: got lat=%0d busy_ready=%b vb=%b want %0d/0/1",
                 n, lat, br, out_valid_b, el);
      else passed++;
      checks++; if (out_a !== m_out[0] || out_b !== m_out[1])
        $display("FAIL rand_%0d_out op=%0d: got %h/%h want %h/%h",
                 n, c.op, out_a, out_b, m_out[0], m_out[1]);
      else passed++;
      checks++; if (err_a !== m_err[0] || err_b !== m_err[1] ||
                    leds_a !== m_leds[0] || leds_b !== m_leds[1])
        $display("FAIL rand_%0d_err_leds: got %b/%b %h/%h want %b/%b %h/%h", n, err_a, err_b,
                 leds_a, leds_b, m_err[0], m_err[1], m_leds[0], m_leds[1]);
      else passed++;
      release_result();
    end
  endtask

  task automatic test_reset_mid_mul();
    cmd_t c;
    int el, lat;
    bit br;
    c = mk(4'hF, 4'hF, 3'd0);
    apply_model(c, el);
    run_cmd(c, lat, br);
    release_result();
    @(negedge clk);
    drive(mk(4'h7, 4'h9, 3'd3));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_a, out_b} !== 16'h0 || {leds_a, leds_b} !== 32'h0 ||
                  {err_a, err_b} !== 2'b00)
      $display("FAIL midmul_reset_regs: got out=%h leds=%h err=%b want 0",
               {out_a, out_b}, {leds_a, leds_b}, {err_a, err_b});
    else passed++;
    checks++; if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b} !== 4'b1100)
      $display("FAIL midmul_reset_hs: got %b want 1100",
               {in_ready_a, in_ready_b, out_valid_a, out_valid_b});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (W + 3) @(negedge clk);
    checks++; if (out_valid_a !== 1'b0 || out_a !== 8'h00)
      $display("FAIL midmul_lost: got valid=%b out=%h want 0/00", out_valid_a, out_a);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(4'h0, 4'h0, 3'd0));
    test_reset();
    test_and();
    test_add();
    test_mul();
    test_invalid();
    test_bypass_backpressure();
    test_shift_rotate();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
